// File: rtl/mipi_hs_byte_align_pkg.sv
// ---------------------------------------------------------------------------
// mipi_hs_byte_align_pkg
// Shared definitions for the MIPI D-PHY HS lane byte aligner and the sync
// detector it uses:
//   MIPI_SYNC_BYTE - HS sync pattern (LSB first on the wire)
//   WIN_W          - width of the sliding window that the candidates reach
//   state_t        - aligner FSM states
//   select_byte()  - pick the 8-bit slice starting at bit k of the window
// ---------------------------------------------------------------------------
package mipi_hs_byte_align_pkg;

    // HS sync byte. On the wire this is 0,0,0,1,1,1,0,1 in time order.
    localparam logic [7:0] MIPI_SYNC_BYTE = 8'hB8;

    // The window is {din, din_q}. Candidate k (0..7) covers bits k+7:k, so
    // the top bit of din is never part of a candidate and is left out.
    localparam int WIN_W = 15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DROP    = 3'd1,
        ST_HUNT    = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_WAIT_LP = 3'd4
    } state_t;

    // Aligned byte at bit offset k of the window; bit 0 of the result is the
    // earliest bit on the wire.
    function automatic logic [7:0] select_byte(input logic [WIN_W-1:0] w,
                                               input logic [2:0]       k);
        return w[k +: 8];
    endfunction

endpackage

// File: rtl/mipi_sync_detect.sv
// ---------------------------------------------------------------------------
// mipi_sync_detect
// Combinational sync-pattern search over the 8 possible bit offsets of a
// sliding window. Also used by the clock-lane checker.
// Ports:
//   w        in  15  window {din[6:0], din_q}; w[0] is earliest in time
//   pattern  in   8  pattern to look for (normally MIPI_SYNC_BYTE)
//   hit      out  1  some offset matches
//   k        out  3  lowest matching offset (0 when no hit)
// ---------------------------------------------------------------------------
module mipi_sync_detect
    import mipi_hs_byte_align_pkg::*;
(
    input  logic [WIN_W-1:0] w,
    input  logic [7:0]       pattern,
    output logic             hit,
    output logic [2:0]       k
);

    logic [7:0] match;

    // One comparator per candidate offset.
    always_comb begin
        match = '0;
        for (int i = 0; i < 8; i++) begin
            match[i] = (select_byte(w, 3'(i)) == pattern);
        end
    end

    // Priority encoder: scanning from the top down lets the lowest matching
    // offset overwrite any higher one, so the earliest alignment wins.
    always_comb begin
        hit = |match;
        k   = '0;
        for (int i = 7; i >= 0; i--) begin
            if (match[i]) begin
                k = 3'(i);
            end
        end
    end

endmodule

// File: rtl/mipi_hs_byte_align.sv
// ---------------------------------------------------------------------------
// mipi_hs_byte_align
// Byte aligner for one MIPI D-PHY HS data lane. Takes unaligned 8-bit words
// from the 1:8 DDR deserializer, discards the settle words after HS entry,
// hunts for the sync byte at any of 8 bit offsets and, once locked, emits
// aligned payload bytes with a valid strobe (no backpressure).
// Ports:
//   gclk        in   1  fabric clock (deserializer CLKDIV)
//   rst         in   1  synchronous active-high reset
//   din         in   8  deserializer word; din[0] earliest in time
//   hs_en       in   1  lane is in HS mode; low = LP / idle
//   dout        out  8  aligned byte, LSB = first bit on wire
//   dout_valid  out  1  dout holds a payload byte
//   sync_ok     out  1  one-cycle pulse when lock is acquired
//   sync_err    out  1  one-cycle pulse when the hunt times out
//   locked      out  1  high while in LOCKED
//   offset      out  3  bit offset in use (meaningful while locked)
// ---------------------------------------------------------------------------
module mipi_hs_byte_align
    import mipi_hs_byte_align_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = MIPI_SYNC_BYTE,
    parameter int         DROP_WORDS   = 1,
    parameter int         HUNT_TIMEOUT = 1024
) (
    input  logic       gclk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       hs_en,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       sync_ok,
    output logic       sync_err,
    output logic       locked,
    output logic [2:0] offset
);

    // One counter serves both the drop window and the hunt timeout; it must
    // hold the larger of the two terminal counts.
    localparam int CNT_MAX = (HUNT_TIMEOUT > DROP_WORDS) ? HUNT_TIMEOUT : DROP_WORDS;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HUNT_LAST = CW'(HUNT_TIMEOUT - 1);
    localparam logic [CW-1:0] DROP_LAST = CW'((DROP_WORDS > 0) ? DROP_WORDS - 1 : 0);

    state_t           state;
    state_t           state_d;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_d;
    logic [7:0]       din_q;
    logic [WIN_W-1:0] win;
    logic             hit;
    logic [2:0]       hit_k;

    logic [2:0]       offset_d;
    logic [7:0]       dout_d;
    logic             dout_valid_d;
    logic             sync_ok_d;
    logic             sync_err_d;

    // Sliding window: previous word in the low bits, current word above it,
    // so increasing bit index means later in time.
    assign win = {din[6:0], din_q};

    mipi_sync_detect u_sync_detect (
        .w       (win),
        .pattern (SYNC_BYTE),
        .hit     (hit),
        .k       (hit_k)
    );

    // State, counter, delayed word and all outputs are registered here.
    // The delayed word is captured every cycle regardless of state so the
    // window is already full by the time the hunt begins.
    always_ff @(posedge gclk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            din_q      <= '0;
            offset     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            sync_ok    <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            din_q      <= din;
            offset     <= offset_d;
            dout       <= dout_d;
            dout_valid <= dout_valid_d;
            sync_ok    <= sync_ok_d;
            sync_err   <= sync_err_d;
        end
    end

    assign locked = (state == ST_LOCKED);

    // Next-state and next-output logic. Leaving HS mode beats everything
    // else, including a sync match or a timeout in the same cycle, and it
    // stops output on that very edge so the trailing word is never emitted.
    // Once locked the offset is frozen; a payload byte equal to the sync
    // pattern is just data.
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        offset_d     = offset;
        dout_d       = '0;
        dout_valid_d = 1'b0;
        sync_ok_d    = 1'b0;
        sync_err_d   = 1'b0;

        if (!hs_en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (DROP_WORDS == 0) begin
                        state_d = ST_HUNT;
                    end else begin
                        state_d = ST_DROP;
                    end
                end

                ST_DROP: begin
                    if (cnt == DROP_LAST) begin
                        state_d = ST_HUNT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end

                ST_HUNT: begin
                    if (hit) begin
                        state_d   = ST_LOCKED;
                        offset_d  = hit_k;
                        sync_ok_d = 1'b1;
                        cnt_d     = '0;
                    end else if (cnt == HUNT_LAST) begin
                        state_d    = ST_WAIT_LP;
                        sync_err_d = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end

                ST_LOCKED: begin
                    dout_d       = select_byte(win, offset);
                    dout_valid_d = 1'b1;
                end

                ST_WAIT_LP: begin
                    state_d = ST_WAIT_LP;
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule
